// File: rtl/c3demo_ledpanel.sv
// c3demo_ledpanel: scan driver for a 32x32 HUB75-style LED panel.
// Pixels written from the CPU IO window land in a two-bank framebuffer
// (top half / bottom half of the panel). The scanner runs forever, shifting
// one row's worth of one bit-plane per pass and lighting it for a time that
// doubles with each plane, which gives binary-coded brightness modulation.
module c3demo_ledpanel #(
    parameter int BITS    = 4,
    parameter int ON_BASE = 32
) (
    input  logic        clk,
    input  logic        resetn,
    // Write port handshake: wr_enable is a valid-only strobe. There is no
    // ready; every cycle with wr_enable=1 is one accepted pixel write.
    input  logic        wr_enable,
    input  logic [4:0]  wr_addr_x,
    input  logic [4:0]  wr_addr_y,
    input  logic [23:0] wr_rgb_data,
    output logic        PANEL_R0,
    output logic        PANEL_G0,
    output logic        PANEL_B0,
    output logic        PANEL_R1,
    output logic        PANEL_G1,
    output logic        PANEL_B1,
    output logic        PANEL_A,
    output logic        PANEL_B,
    output logic        PANEL_C,
    output logic        PANEL_D,
    output logic        PANEL_CLK,
    output logic        PANEL_STB,
    output logic        PANEL_OE
);
    localparam int PW       = 3 * BITS;
    localparam int DISP_MAX = ON_BASE << (BITS - 1);
    // Counter must reach 64 (SHIFT) and DISP_MAX-1 (longest DISPLAY).
    localparam int CW       = (DISP_MAX > 64) ? $clog2(DISP_MAX) + 1 : 7;

    localparam logic [1:0] ST_SHIFT   = 2'd0;
    localparam logic [1:0] ST_BLANK   = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;
    localparam logic [1:0] ST_DISPLAY = 2'd3;

    localparam logic [2:0]    PLANE_LAST = 3'(BITS - 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(64);
    localparam logic [CW-1:0] ON_BASE_W  = CW'(ON_BASE);

    // Framebuffer: bank 0 holds rows 0..15, bank 1 rows 16..31.
    // Pixel word layout is {R[BITS-1:0], G[BITS-1:0], B[BITS-1:0]}.
    logic [PW-1:0] fb0 [0:511];
    logic [PW-1:0] fb1 [0:511];
    logic [PW-1:0] fb0_rd;
    logic [PW-1:0] fb1_rd;

    logic [PW-1:0] wr_pix;
    logic [8:0]    wr_idx;
    logic          wr_unused;

    // Scanner state; state_q is the FSM state visible to checkers.
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    row_q, row_d;
    logic [2:0]    plane_q, plane_d;
    logic [CW-1:0] disp_len;

    logic          rd_en;
    logic [4:0]    rd_col;
    logic [8:0]    rd_idx;
    logic [BITS-1:0] plane_mask;
    logic [5:0]    pix_bits;

    // Registered panel outputs.
    logic          oe_q, oe_d;
    logic          stb_q, stb_d;
    logic          pclk_q, pclk_d;
    logic [5:0]    rgb_q, rgb_d;
    logic [3:0]    row_sel_q, row_sel_d;

    assign wr_pix    = {wr_rgb_data[23 -: BITS], wr_rgb_data[15 -: BITS], wr_rgb_data[7 -: BITS]};
    assign wr_idx    = {wr_addr_y[3:0], wr_addr_x};
    // Low channel bits below the stored MSBs are intentionally dropped.
    assign wr_unused = ^wr_rgb_data;

    // Bank 0 write port (rows 0..15).
    always_ff @(posedge clk) begin
        if (wr_enable && !wr_addr_y[4]) fb0[wr_idx] <= wr_pix;
    end

    // Bank 1 write port (rows 16..31).
    always_ff @(posedge clk) begin
        if (wr_enable && wr_addr_y[4]) fb1[wr_idx] <= wr_pix;
    end

    // Read side: the address follows the *next* scan position, so the word
    // for column 31 is already in fb*_rd while SHIFT step 0 is current and
    // can be registered onto the pins on step 1. Columns run 31 down to 0,
    // one per even step. A same-address write in the same cycle is not seen
    // (read-before-write), and the write still lands.
    assign rd_en  = (state_d == ST_SHIFT) && !cnt_d[0];
    assign rd_col = 5'd31 - cnt_d[5:1];
    assign rd_idx = {row_d, rd_col};

    // Registered read ports of both banks.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            fb0_rd <= fb0[rd_idx];
            fb1_rd <= fb1[rd_idx];
        end
    end

    assign disp_len   = ON_BASE_W << plane_q;
    assign plane_mask = BITS'(1) << plane_q;
    assign pix_bits   = {|(fb0_rd[2*BITS +: BITS] & plane_mask),
                         |(fb0_rd[BITS   +: BITS] & plane_mask),
                         |(fb0_rd[0      +: BITS] & plane_mask),
                         |(fb1_rd[2*BITS +: BITS] & plane_mask),
                         |(fb1_rd[BITS   +: BITS] & plane_mask),
                         |(fb1_rd[0      +: BITS] & plane_mask)};

    // Scan sequencing. Reset is folded in here so the read address seen
    // during reset already points at row 0, column 31.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        row_d   = row_q;
        plane_d = plane_q;
        case (state_q)
            ST_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end
            ST_BLANK: begin
                state_d = ST_LATCH;
                cnt_d   = '0;
            end
            ST_LATCH: begin
                state_d = ST_DISPLAY;
                cnt_d   = '0;
            end
            default: begin
                if (cnt_q == disp_len - 1'b1) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        row_d   = row_q + 1'b1;
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                end
            end
        endcase
        if (!resetn) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            row_d   = '0;
            plane_d = '0;
        end
    end

    // Panel outputs are decoded from the next state so the pins line up
    // with the state register cycle for cycle.
    always_comb begin
        oe_d      = (state_d != ST_DISPLAY);
        stb_d     = (state_d == ST_LATCH);
        pclk_d    = (state_d == ST_SHIFT) && !cnt_d[0] && (|cnt_d);
        rgb_d     = rgb_q;
        row_sel_d = row_sel_q;
        if ((state_d == ST_SHIFT) && cnt_d[0]) rgb_d = pix_bits;
        if (state_d == ST_BLANK) row_sel_d = row_q;
        if (!resetn) begin
            rgb_d     = '0;
            row_sel_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        row_q     <= row_d;
        plane_q   <= plane_d;
        oe_q      <= oe_d;
        stb_q     <= stb_d;
        pclk_q    <= pclk_d;
        rgb_q     <= rgb_d;
        row_sel_q <= row_sel_d;
    end

    assign {PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1} = rgb_q;
    assign {PANEL_D, PANEL_C, PANEL_B, PANEL_A} = row_sel_q;
    assign PANEL_CLK = pclk_q;
    assign PANEL_STB = stb_q;
    assign PANEL_OE  = oe_q;

endmodule

// File: tb/tb_c3demo_ledpanel.sv
// Directed bench for c3demo_ledpanel: startup timing, pixel placement,
// bit-plane modulation, frame timing and reset during DISPLAY.
`timescale 1ns/1ps
module tb_c3demo_ledpanel;
    localparam int BITS    = 4;
    localparam int ON_BASE = 32;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_enable = 1'b0;
    logic [4:0]  wr_addr_x = '0;
    logic [4:0]  wr_addr_y = '0;
    logic [23:0] wr_rgb_data = '0;
    logic PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1;
    logic PANEL_A, PANEL_B, PANEL_C, PANEL_D, PANEL_CLK, PANEL_STB, PANEL_OE;
    logic [12:0] outs;

    always #5 clk = ~clk;

    c3demo_ledpanel #(.BITS(BITS), .ON_BASE(ON_BASE)) dut (
        .clk(clk), .resetn(resetn), .wr_enable(wr_enable),
        .wr_addr_x(wr_addr_x), .wr_addr_y(wr_addr_y), .wr_rgb_data(wr_rgb_data),
        .PANEL_R0(PANEL_R0), .PANEL_G0(PANEL_G0), .PANEL_B0(PANEL_B0),
        .PANEL_R1(PANEL_R1), .PANEL_G1(PANEL_G1), .PANEL_B1(PANEL_B1),
        .PANEL_A(PANEL_A), .PANEL_B(PANEL_B), .PANEL_C(PANEL_C), .PANEL_D(PANEL_D),
        .PANEL_CLK(PANEL_CLK), .PANEL_STB(PANEL_STB), .PANEL_OE(PANEL_OE)
    );

    assign outs = {PANEL_OE, PANEL_STB, PANEL_CLK, PANEL_R0, PANEL_G0, PANEL_B0,
                   PANEL_R1, PANEL_G1, PANEL_B1, PANEL_D, PANEL_C, PANEL_B, PANEL_A};

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];   // expected OE-low length of each pending DISPLAY
    bit   mon_en = 1'b0;
    int   cyc, stb_total, edge_idx, oe_low_cnt;
    int   first_stb, second_stb, first_oe_low;
    int   pend_row, pwm_sum;
    int   overlap = 0, stb_long = 0, hold_viol = 0;
    int   frame_t[3];
    logic [31:0] pend_r0;
    logic prev_pclk, prev_stb;
    logic [5:0] prev_data;
    logic [31:0] r0v, g0v, b0v, r1v, g1v, b1v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on each STB pulse: the SHIFT just finished belongs to this
    // (row, plane); the DISPLAY that preceded it is closed out here.
    task automatic on_stb();
        int plane, row;
        logic [31:0] e_r0, e_b1, e_on;
        plane = stb_total % BITS;
        row   = (stb_total / BITS) % 16;
        if (first_stb < 0) first_stb = cyc;
        else if (second_stb < 0) second_stb = cyc;
        if (plane == 0 && row == 0 && (stb_total / 64) < 3) frame_t[stb_total / 64] = cyc;
        if (exp_q.size() > 0) begin
            e_on = exp_q.pop_front();
            check("oe_low_len", oe_low_cnt, e_on);
            if (pend_row == 3 && pend_r0[26]) pwm_sum += oe_low_cnt;
        end
        check($sformatf("row_sel stb%0d", stb_total), {PANEL_D, PANEL_C, PANEL_B, PANEL_A}, row);
        check($sformatf("clk_edges stb%0d", stb_total), edge_idx, 32);
        e_r0 = 32'h0;
        e_b1 = 32'h0;
        if (row == 0) begin
            e_r0 = 32'h0000_0001;   // x=31 is the first edge
            e_b1 = 32'h8000_0000;   // x=0 is the 32nd edge
        end
        if (row == 3 && (plane == 0 || plane == 2)) e_r0 = 32'h0400_0000; // x=5
        check($sformatf("r0 row%0d plane%0d", row, plane), r0v, e_r0);
        check($sformatf("g0 row%0d plane%0d", row, plane), g0v, 32'h0);
        check($sformatf("b0 row%0d plane%0d", row, plane), b0v, 32'h0);
        check($sformatf("r1 row%0d plane%0d", row, plane), r1v, 32'h0);
        check($sformatf("g1 row%0d plane%0d", row, plane), g1v, 32'h0);
        check($sformatf("b1 row%0d plane%0d", row, plane), b1v, e_b1);
        exp_q.push_back(32'(ON_BASE << plane));
        pend_row = row;
        pend_r0  = r0v;
        stb_total++;
        edge_idx = 0;
        oe_low_cnt = 0;
        {r0v, g0v, b0v, r1v, g1v, b1v} = '0;
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; sample outputs on the falling edge.
    task automatic step();
        logic [5:0] data;
        @(posedge clk);
        @(negedge clk);
        if (mon_en) begin
            cyc++;
            data = {PANEL_R0, PANEL_G0, PANEL_B0, PANEL_R1, PANEL_G1, PANEL_B1};
            if (PANEL_CLK && !prev_pclk) begin
                if (data !== prev_data) hold_viol++;
                if (edge_idx < 32) begin
                    r0v[edge_idx] = PANEL_R0; g0v[edge_idx] = PANEL_G0; b0v[edge_idx] = PANEL_B0;
                    r1v[edge_idx] = PANEL_R1; g1v[edge_idx] = PANEL_G1; b1v[edge_idx] = PANEL_B1;
                end
                edge_idx++;
            end
            if (!PANEL_OE) begin
                oe_low_cnt++;
                if (first_oe_low < 0) first_oe_low = cyc;
            end
            if (!PANEL_OE && PANEL_STB) overlap++;
            if (PANEL_STB && prev_stb) stb_long++;
            if (PANEL_STB && !prev_stb) on_stb();
            prev_pclk = PANEL_CLK;
            prev_stb  = PANEL_STB;
            prev_data = data;
        end
    endtask

    task automatic write_pixel(input logic [4:0] x, input logic [4:0] y, input logic [23:0] rgb);
        wr_enable = 1'b1;
        wr_addr_x = x;
        wr_addr_y = y;
        wr_rgb_data = rgb;
        @(posedge clk);
        @(negedge clk);
        wr_enable = 1'b0;
    endtask

    // Release point: cycle 0 is the period in which resetn first reads 1.
    task automatic restart();
        cyc = 0; stb_total = 0; edge_idx = 0; oe_low_cnt = 0;
        first_stb = -1; second_stb = -1; first_oe_low = -1;
        pend_row = -1; pend_r0 = '0; pwm_sum = 0;
        exp_q.delete();
        prev_pclk = 1'b0; prev_stb = 1'b0; prev_data = '0;
        {r0v, g0v, b0v, r1v, g1v, b1v} = '0;
        mon_en = 1'b1;
    endtask

    task automatic do_reset(input int n);
        mon_en = 1'b0;
        resetn = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check($sformatf("reset_outs c%0d", i), outs, 13'h1000);
        end
        resetn = 1'b1;
        restart();
    endtask

    task automatic check_startup();
        for (int g = 0; g < 400 && stb_total < 2; g++) step();
        check("startup_bound", stb_total >= 2, 1);
        check("first_stb_cycle", first_stb, 66);
        check("first_oe_low_cycle", first_oe_low, 67);
        check("second_stb_cycle", second_stb, 165);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                write_pixel(5'(x), 5'(y), 24'h0);
        write_pixel(5'd31, 5'd0,  24'hFF0000);
        write_pixel(5'd0,  5'd16, 24'h0000FF);
        write_pixel(5'd5,  5'd3,  24'h500000);

        do_reset(3);
        check_startup();

        for (int g = 0; g < 20000 && stb_total < 65; g++) step();
        check("frame1_bound", stb_total >= 65, 1);
        check("pwm_on_sum", pwm_sum, 160);

        for (int g = 0; g < 20000 && stb_total < 160; g++) step();
        check("frame3_bound", stb_total >= 160, 1);
        check("frame_period_1", frame_t[1] - frame_t[0], 11968);
        check("frame_period_2", frame_t[2] - frame_t[1], 11968);
        check("stb_oe_overlap", overlap, 0);
        check("stb_width", stb_long, 0);
        check("data_hold", hold_viol, 0);

        // Now in row 7, plane 3 DISPLAY; reset partway through it.
        repeat (10) step();
        check("mid_display_oe", PANEL_OE, 0);
        do_reset(3);
        check_startup();
        check("restart_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
